// File: rtl/control_types.sv
// control_types: control-signal encodings produced by the decoder
package control_types;

   typedef enum logic [2:0] {
      BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
   } comp_ctrl_t;

   typedef enum logic [1:0] {
      WRSRC_ALURES, WRSRC_MEMOUT, WRSRC_PC4
   } reg_wr_src_ctrl_t;

   typedef enum logic [1:0] {
      SRC1_REG1, SRC1_PC, SRC1_ZERO
   } alu_op1_ctrl_t;

   typedef enum logic [1:0] {
      SRC2_REG2, SRC2_IMM, SRC2_FOUR
   } alu_op2_ctrl_t;

   typedef enum logic [3:0] {
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
      ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      MEM_NOP, MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU
   } mem_ctrl_t;

endpackage

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: ID/EX control bundle and its bubble (NOP) value
package pipeline_pkg;
   import control_types::*;

   typedef struct packed {
      logic             reg_do_write;
      logic             mem_do_write;
      logic             mem_do_read;
      logic             do_branch;
      logic             do_jump;
      comp_ctrl_t       comp;
      reg_wr_src_ctrl_t reg_wr_src;
      alu_op1_ctrl_t    alu_op1;
      alu_op2_ctrl_t    alu_op2;
      alu_ctrl_t        alu;
      mem_ctrl_t        mem;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
      reg_do_write: 1'b0,
      mem_do_write: 1'b0,
      mem_do_read:  1'b0,
      do_branch:    1'b0,
      do_jump:      1'b0,
      comp:         BR_NOP,
      reg_wr_src:   WRSRC_ALURES,
      alu_op1:      SRC1_REG1,
      alu_op2:      SRC2_REG2,
      alu:          ALU_NOP,
      mem:          MEM_NOP
   };

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use detection between the load in EX and the instruction in ID
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  uses_rs1_i,
   input  logic                  uses_rs2_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   output logic                  lu_o
);

   logic ex_load;
   logic dep;

   // a valid load to a non-x0 register in EX blocks any ID consumer of that register
   always_comb begin
      ex_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i;
      dep     = (uses_rs1_i & (id_rs1_i == ex_rd_i)) | (uses_rs2_i & (id_rs2_i == ex_rd_i));
      lu_o    = ex_load & dep;
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush and stall
module id_ex_stage
   import control_types::*;
   import pipeline_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  reg_do_write_ctrl,
   input  logic                  mem_do_write_ctrl,
   input  logic                  mem_do_read_ctrl,
   input  logic                  do_branch,
   input  logic                  do_jump,
   input  comp_ctrl_t            comp_ctrl,
   input  reg_wr_src_ctrl_t      reg_wr_src_ctrl,
   input  alu_op1_ctrl_t         alu_op1_ctrl,
   input  alu_op2_ctrl_t         alu_op2_ctrl,
   input  alu_ctrl_t             alu_ctrl,
   input  mem_ctrl_t             mem_ctrl,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_reg1_data,
   input  logic [XLEN-1:0]       id_reg2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush,
   input  logic                  stall_in,
   output logic                  ex_valid,
   output logic                  ex_reg_do_write_ctrl,
   output logic                  ex_mem_do_write_ctrl,
   output logic                  ex_mem_do_read_ctrl,
   output logic                  ex_do_branch,
   output logic                  ex_do_jump,
   output comp_ctrl_t            ex_comp_ctrl,
   output reg_wr_src_ctrl_t      ex_reg_wr_src_ctrl,
   output alu_op1_ctrl_t         ex_alu_op1_ctrl,
   output alu_op2_ctrl_t         ex_alu_op2_ctrl,
   output alu_ctrl_t             ex_alu_ctrl,
   output mem_ctrl_t             ex_mem_ctrl,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_reg1_data,
   output logic [XLEN-1:0]       ex_reg2_data,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  hazard_stall,
   output logic [CNT_W-1:0]      bubble_cnt
);

   id_ex_ctrl_t           ctrl_q, ctrl_d, id_ctrl;
   logic [XLEN-1:0]       pc_q, pc_d, r1_q, r1_d, r2_q, r2_d, imm_q, imm_d;
   logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                  valid_q, valid_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  uses_rs1, uses_rs2, lu, bubble, hold;

   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .uses_rs1_i    (uses_rs1),
      .uses_rs2_i    (uses_rs2),
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_do_read),
      .ex_rd_i       (rd_q),
      .lu_o          (lu)
   );

   // operand usage, priority mux (flush > stall_in > load-use > advance) and bubble counter
   always_comb begin
      id_ctrl = '{
         reg_do_write: reg_do_write_ctrl,
         mem_do_write: mem_do_write_ctrl,
         mem_do_read:  mem_do_read_ctrl,
         do_branch:    do_branch,
         do_jump:      do_jump,
         comp:         comp_ctrl,
         reg_wr_src:   reg_wr_src_ctrl,
         alu_op1:      alu_op1_ctrl,
         alu_op2:      alu_op2_ctrl,
         alu:          alu_ctrl,
         mem:          mem_ctrl
      };
      uses_rs1 = ((alu_op1_ctrl == SRC1_REG1) & (alu_ctrl != ALU_LUI)) | do_branch;
      uses_rs2 = (alu_op2_ctrl == SRC2_REG2) | mem_do_write_ctrl | do_branch;
      bubble   = flush | (~stall_in & lu);
      hold     = ~flush & stall_in;
      ctrl_d   = bubble ? ID_EX_BUBBLE : hold ? ctrl_q : id_valid ? id_ctrl : ID_EX_BUBBLE;
      valid_d  = ~bubble & (hold ? valid_q : id_valid);
      pc_d     = bubble ? '0 : hold ? pc_q  : id_pc;
      r1_d     = bubble ? '0 : hold ? r1_q  : id_reg1_data;
      r2_d     = bubble ? '0 : hold ? r2_q  : id_reg2_data;
      imm_d    = bubble ? '0 : hold ? imm_q : id_imm;
      rs1_d    = bubble ? '0 : hold ? rs1_q : id_rs1;
      rs2_d    = bubble ? '0 : hold ? rs2_q : id_rs2;
      rd_d     = bubble ? '0 : hold ? rd_q  : id_rd;
      cnt_d    = (bubble & ~stall_in & (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // EX register bank; asynchronous reset returns everything to the bubble value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= ID_EX_BUBBLE;
         valid_q <= 1'b0;
         pc_q    <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         pc_q    <= pc_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         imm_q   <= imm_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hazard_stall         = lu & ~flush;
   assign ex_valid             = valid_q;
   assign ex_reg_do_write_ctrl = ctrl_q.reg_do_write;
   assign ex_mem_do_write_ctrl = ctrl_q.mem_do_write;
   assign ex_mem_do_read_ctrl  = ctrl_q.mem_do_read;
   assign ex_do_branch         = ctrl_q.do_branch;
   assign ex_do_jump           = ctrl_q.do_jump;
   assign ex_comp_ctrl         = ctrl_q.comp;
   assign ex_reg_wr_src_ctrl   = ctrl_q.reg_wr_src;
   assign ex_alu_op1_ctrl      = ctrl_q.alu_op1;
   assign ex_alu_op2_ctrl      = ctrl_q.alu_op2;
   assign ex_alu_ctrl          = ctrl_q.alu;
   assign ex_mem_ctrl          = ctrl_q.mem;
   assign ex_pc                = pc_q;
   assign ex_reg1_data         = r1_q;
   assign ex_reg2_data         = r2_q;
   assign ex_imm               = imm_q;
   assign ex_rs1               = rs1_q;
   assign ex_rs2               = rs2_q;
   assign ex_rd                = rd_q;
   assign bubble_cnt           = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for the ID/EX register and load-use logic
module tb_id_ex_stage;
   import control_types::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic             reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch, do_jump;
   comp_ctrl_t       comp_ctrl;
   reg_wr_src_ctrl_t reg_wr_src_ctrl;
   alu_op1_ctrl_t    alu_op1_ctrl;
   alu_op2_ctrl_t    alu_op2_ctrl;
   alu_ctrl_t        alu_ctrl;
   mem_ctrl_t        mem_ctrl;
   logic [31:0]      id_pc, id_reg1_data, id_reg2_data, id_imm;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             flush, stall_in;

   logic             ex_valid, ex_reg_do_write_ctrl, ex_mem_do_write_ctrl, ex_mem_do_read_ctrl;
   logic             ex_do_branch, ex_do_jump;
   comp_ctrl_t       ex_comp_ctrl;
   reg_wr_src_ctrl_t ex_reg_wr_src_ctrl;
   alu_op1_ctrl_t    ex_alu_op1_ctrl;
   alu_op2_ctrl_t    ex_alu_op2_ctrl;
   alu_ctrl_t        ex_alu_ctrl;
   mem_ctrl_t        ex_mem_ctrl;
   logic [31:0]      ex_pc, ex_reg1_data, ex_reg2_data, ex_imm;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic             hazard_stall;
   logic [15:0]      bubble_cnt;

   int n_vec = 0;
   int n_err = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .reg_do_write_ctrl(reg_do_write_ctrl), .mem_do_write_ctrl(mem_do_write_ctrl),
      .mem_do_read_ctrl(mem_do_read_ctrl), .do_branch(do_branch), .do_jump(do_jump),
      .comp_ctrl(comp_ctrl), .reg_wr_src_ctrl(reg_wr_src_ctrl), .alu_op1_ctrl(alu_op1_ctrl),
      .alu_op2_ctrl(alu_op2_ctrl), .alu_ctrl(alu_ctrl), .mem_ctrl(mem_ctrl),
      .id_pc(id_pc), .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .stall_in(stall_in),
      .ex_valid(ex_valid), .ex_reg_do_write_ctrl(ex_reg_do_write_ctrl),
      .ex_mem_do_write_ctrl(ex_mem_do_write_ctrl), .ex_mem_do_read_ctrl(ex_mem_do_read_ctrl),
      .ex_do_branch(ex_do_branch), .ex_do_jump(ex_do_jump), .ex_comp_ctrl(ex_comp_ctrl),
      .ex_reg_wr_src_ctrl(ex_reg_wr_src_ctrl), .ex_alu_op1_ctrl(ex_alu_op1_ctrl),
      .ex_alu_op2_ctrl(ex_alu_op2_ctrl), .ex_alu_ctrl(ex_alu_ctrl), .ex_mem_ctrl(ex_mem_ctrl),
      .ex_pc(ex_pc), .ex_reg1_data(ex_reg1_data), .ex_reg2_data(ex_reg2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      id_valid = 1'b0;
      reg_do_write_ctrl = 1'b0; mem_do_write_ctrl = 1'b0; mem_do_read_ctrl = 1'b0;
      do_branch = 1'b0; do_jump = 1'b0;
      comp_ctrl = BR_NOP; reg_wr_src_ctrl = WRSRC_ALURES;
      alu_op1_ctrl = SRC1_REG1; alu_op2_ctrl = SRC2_REG2;
      alu_ctrl = ALU_NOP; mem_ctrl = MEM_NOP;
      id_pc = '0; id_reg1_data = '0; id_reg2_data = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;
   endtask

   task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      set_nop();
      id_valid = 1'b1; reg_do_write_ctrl = 1'b1; alu_ctrl = ALU_ADD;
      id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_pc = 32'h200; id_reg1_data = 32'd11; id_reg2_data = 32'd22;
   endtask

   task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
      set_nop();
      id_valid = 1'b1; reg_do_write_ctrl = 1'b1; mem_do_read_ctrl = 1'b1;
      reg_wr_src_ctrl = WRSRC_MEMOUT; alu_op2_ctrl = SRC2_IMM;
      alu_ctrl = ALU_ADD; mem_ctrl = MEM_W;
      id_rd = rd; id_rs1 = rs1; id_pc = 32'h100;
   endtask

   task automatic set_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f,
                           input logic [31:0] imm);
      set_nop();
      id_valid = 1'b1; reg_do_write_ctrl = 1'b1; alu_op2_ctrl = SRC2_IMM; alu_ctrl = ALU_ADD;
      id_rd = rd; id_rs1 = rs1; id_rs2 = rs2f; id_imm = imm;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; stall_in = 1'b0;
      set_nop();
      #12;
      chk("rst_valid", ex_valid, 0);
      chk("rst_cnt", bubble_cnt, 0);
      chk("rst_stall", hazard_stall, 0);
      chk("rst_pc", ex_pc, 0);
      chk("rst_alu", ex_alu_ctrl, ALU_NOP);
      rst_n = 1'b1;
      tick();
      // ADD x3,x1,x2
      set_add(5'd3, 5'd1, 5'd2);
      #1 chk("add_stall", hazard_stall, 0);
      tick();
      chk("add_rd", ex_rd, 3);
      chk("add_op2", ex_alu_op2_ctrl, SRC2_REG2);
      chk("add_valid", ex_valid, 1);
      chk("add_pc", ex_pc, 32'h200);
      chk("add_r1", ex_reg1_data, 11);
      chk("add_alu", ex_alu_ctrl, ALU_ADD);
      // LW x5 then dependent ADD x6,x5,x7
      set_lw(5'd5, 5'd1);
      #1 chk("lw_nostall", hazard_stall, 0);
      tick();
      chk("lw_rd", ex_rd, 5);
      chk("lw_rdctl", ex_mem_do_read_ctrl, 1);
      set_add(5'd6, 5'd5, 5'd7);
      #1 chk("lu_stall", hazard_stall, 1);
      tick();
      chk("lu_bub_valid", ex_valid, 0);
      chk("lu_bub_alu", ex_alu_ctrl, ALU_NOP);
      chk("lu_bub_rd", ex_rd, 0);
      chk("lu_cnt", bubble_cnt, 1);
      chk("lu_stall_gone", hazard_stall, 0);
      tick();
      chk("lu_add_rd", ex_rd, 6);
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_cnt2", bubble_cnt, 1);
      // LW x5 then ADDI x6,x0,5 with rs2 field 5
      set_lw(5'd5, 5'd1);
      tick();
      set_addi(5'd6, 5'd0, 5'd5, 32'd5);
      #1 chk("addi_stall", hazard_stall, 0);
      tick();
      chk("addi_rd", ex_rd, 6);
      chk("addi_imm", ex_imm, 5);
      // LW x0 then ADD x1,x0,x0
      set_lw(5'd0, 5'd1);
      tick();
      set_add(5'd1, 5'd0, 5'd0);
      #1 chk("x0_stall", hazard_stall, 0);
      tick();
      chk("x0_rd", ex_rd, 1);
      chk("x0_cnt", bubble_cnt, 1);
      // flush together with load-use
      set_lw(5'd5, 5'd1);
      tick();
      set_add(5'd6, 5'd5, 5'd7);
      flush = 1'b1;
      #1 chk("fl_stall", hazard_stall, 0);
      tick();
      flush = 1'b0;
      chk("fl_valid", ex_valid, 0);
      chk("fl_rd", ex_rd, 0);
      chk("fl_cnt", bubble_cnt, 2);
      // stall_in during load-use for 3 cycles
      set_lw(5'd5, 5'd1);
      tick();
      set_add(5'd6, 5'd5, 5'd7);
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("si_stall", hazard_stall, 1);
         tick();
         chk("si_rd", ex_rd, 5);
         chk("si_rdctl", ex_mem_do_read_ctrl, 1);
         chk("si_cnt", bubble_cnt, 2);
      end
      stall_in = 1'b0;
      #1 chk("si_rel_stall", hazard_stall, 1);
      tick();
      chk("si_bub_valid", ex_valid, 0);
      chk("si_bub_cnt", bubble_cnt, 3);
      tick();
      chk("si_add_rd", ex_rd, 6);
      chk("si_add_valid", ex_valid, 1);
      // flush together with stall_in squashes the held instruction
      set_add(5'd9, 5'd1, 5'd2);
      tick();
      chk("fs_pre_rd", ex_rd, 9);
      flush = 1'b1; stall_in = 1'b1;
      tick();
      chk("fs_valid", ex_valid, 0);
      chk("fs_rd", ex_rd, 0);
      stall_in = 1'b0;
      // saturation: 2^16 + 3 flushes
      repeat (65539) @(posedge clk);
      #1 chk("sat_cnt", bubble_cnt, 16'hFFFF);
      flush = 1'b0;
      // async reset in the middle of a load-use stall
      set_lw(5'd5, 5'd1);
      tick();
      set_add(5'd6, 5'd5, 5'd7);
      #1 chk("ar_pre_stall", hazard_stall, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_stall", hazard_stall, 0);
      chk("ar_valid", ex_valid, 0);
      chk("ar_cnt", bubble_cnt, 0);
      chk("ar_rd", ex_rd, 0);
      chk("ar_rdctl", ex_mem_do_read_ctrl, 0);
      chk("ar_pc", ex_pc, 0);
      chk("ar_mem", ex_mem_ctrl, MEM_NOP);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage RISC-V core. It sits directly downstream of `control`. It captures the control-signal bundle and the decoded operands of the instruction in ID. It also detects load-use hazards, inserting a single bubble and stalling the front end, and it honours flush (from EX branch/jump resolution) and back-pressure stall from later stages.

## Interface

**Parameters**
- `XLEN`, 32, datapath width.
- `REG_ADDR_W`, 5, register index width.
- `CNT_W`, 16, bubble counter width.

**Ports**
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `reg_do_write_ctrl`, `mem_do_write_ctrl`, `mem_do_read_ctrl`, `do_branch`, `do_jump`  in  1 each  from `control`.
- `comp_ctrl`, `reg_wr_src_ctrl`, `alu_op1_ctrl`, `alu_op2_ctrl`, `alu_ctrl`, `mem_ctrl`  in  enum types  from `control`.
- `id_pc`, `id_reg1_data`, `id_reg2_data`, `id_imm`  in  XLEN each  ID operands.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR_W each  register indices.
- `flush`  in  1  squash the ID instruction (taken branch/jump in EX).
- `stall_in`  in  1  downstream back-pressure; hold the EX register.
- `ex_*`  out  same as inputs  registered copies of every control, data and index input above, plus `ex_valid`.
- `hazard_stall`  out  1  hold PC and IF/ID this cycle.
- `bubble_cnt`  out  CNT_W  saturating count of inserted bubbles.

## Operation

- Bubble value = NOP control:
  - all write/read/branch/jump bits 0;
  - `BR_NOP`, `WRSRC_ALURES`, `SRC1_REG1`, `SRC2_REG2`, `ALU_NOP`, `MEM_NOP`;
  - `ex_valid` 0; data and index fields 0.
- Operand usage, derived from the incoming control inputs:
  - `uses_rs1` = (`alu_op1_ctrl`==`SRC1_REG1` & `alu_ctrl`!=`ALU_LUI`) | `do_branch`.
  - `uses_rs2` = `alu_op2_ctrl`==`SRC2_REG2` | `mem_do_write_ctrl` | `do_branch`.
- Load-use condition (`lu`):
  - `ex_valid` & `ex_mem_do_read_ctrl` & `ex_rd`!=0 & `id_valid`;
  - and either (`uses_rs1` & `id_rs1`==`ex_rd`) or (`uses_rs2` & `id_rs2`==`ex_rd`).
- `hazard_stall` = `lu` & ~`flush`. It is combinational and valid in the same cycle.
- Register update per clock edge, in priority order:
  1. `flush`: load bubble.
  2. `stall_in`: hold all `ex_*`.
  3. `lu`: load bubble.
  4. Otherwise: load the ID inputs. `ex_valid` = `id_valid`. If `id_valid`=0, the control fields load as bubble.
- `bubble_cnt` increments on edges where a bubble is loaded because of `flush` or `lu` while `stall_in`=0. It saturates at all-ones and does not wrap.

## Timing

- Reset (`rst_n` low, asynchronous): all `ex_*` take the bubble value, `ex_pc`=0, `ex_valid`=0, `bubble_cnt`=0. `hazard_stall` is 0 while in reset because `ex_valid`=0. Reset mid-stall drops the stall immediately.
- Latency: an ID input appears on `ex_*` one clock after the capturing edge.
- Load-use: a LW in EX with a dependent instruction in ID gives `hazard_stall`=1 for exactly one cycle. The next edge loads a bubble while IF/ID holds. On the following cycle `ex_valid`=0, so `lu`=0 and the dependent instruction advances.
- `stall_in` during `lu`: the EX register holds the LW, `hazard_stall` stays high, and no bubble is counted until `stall_in` drops.
- `flush` together with `lu`: the flush wins, `hazard_stall`=0, and one bubble is counted.
- `flush` together with `stall_in`: the flush wins, so the squashed instruction is never held.
- `ex_rd`==x0 never causes a stall.

## Structure

- Package `pipeline_pkg`:
  - struct `id_ex_ctrl_t` bundling the eleven control fields (using the existing `control_types` enums);
  - constant `ID_EX_BUBBLE` of type `id_ex_ctrl_t`.
- Sub-module `hazard_detect`: combinational; computes `lu` from the ID indices, the usage signals and the EX load state.
- Top-level: register bank, priority mux and counter.

## Test plan

- Reset, then `ADD x3,x1,x2` with `id_valid`=1 → next cycle `ex_rd`=3, `ex_alu_op2_ctrl`=`SRC2_REG2`, `ex_valid`=1, `hazard_stall`=0.
- `LW x5,0(x1)` followed by `ADD x6,x5,x7` → `hazard_stall`=1 for one cycle, one bubble in EX (`ex_valid`=0, `ALU_NOP`), ADD enters EX one cycle later, `bubble_cnt`=1.
- `LW x5` then `ADDI x6,x0,5` whose rs2 field = 5 → no stall, because the ADDI does not use rs2.
- `LW x0` then `ADD x1,x0,x0` → no stall.
- `LW x5` plus a dependent ADD with `flush`=1 in the same cycle → `hazard_stall`=0, bubble loaded, `bubble_cnt` +1. Same case with `stall_in`=1 for 3 cycles first → LW held in EX, `hazard_stall`=1 throughout, `bubble_cnt` unchanged until release.
- Force 2^CNT_W + 3 flushes → `bubble_cnt` saturates at 0xFFFF. Then pulse `rst_n` low mid-stall → all outputs return to the bubble/zero values asynchronously.
